serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor.
// Contents:
//   IDLE / BUSY / DONE : FSM state encodings. They are kept here so that
//                        anything observing the state register agrees on
//                        the same values.
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full subtractor. It computes a - b - bin for a
// single bit position.
// Ports:
//   a      : in  minuend bit
//   b      : in  subtrahend bit
//   bin    : in  borrow from the previous (less significant) bit
//   diff   : out difference bit
//   borrow : out borrow into the next (more significant) bit
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ bin;
    // A borrow is needed when b exceeds a outright, or when the bits are
    // equal and a borrow is already coming in.
    assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor. It computes a - b - bin one bit per clock, LSB
// first, using a single full_subtractor cell.
// Ports:
//   clk      : in  clock; all state updates on the rising edge
//   rst      : in  asynchronous active-high reset
//   start    : in  request to subtract; sampled only while idle
//   a, b     : in  WIDTH-bit minuend and subtrahend
//   bin      : in  borrow-in
//   diff     : out WIDTH-bit result a - b - bin (mod 2^WIDTH)
//   borrow   : out unsigned borrow-out
//   overflow : out two's-complement signed overflow
//   busy     : out high while an operation is in flight or completing
//   done     : out one-cycle pulse when diff/borrow/overflow are valid
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    import serial_sub_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic             br_q,       br_d;
    logic [WIDTH-1:0] diff_q,     diff_d;
    logic             borrow_q,   borrow_d;
    logic             overflow_q, overflow_d;

    logic bit_diff;
    logic bit_borrow;

    // The operand registers shift right every BUSY cycle, so bit 0 is
    // always the bit currently being processed.
    full_subtractor u_fs (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .bin    (br_q),
        .diff   (bit_diff),
        .borrow (bit_borrow)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        br_d       = br_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // After WIDTH shifts in from the top, the first bit
                // produced ends up in diff[0].
                diff_d = {bit_diff, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = bit_borrow;
                if (cnt_q == LAST_BIT) begin
                    // On the last bit, bit 0 of the shifted operands holds
                    // the original sign bits, and bit_diff is the result's
                    // sign bit.
                    borrow_d   = bit_borrow;
                    overflow_d = (a_q[0] ^ b_q[0]) & (a_q[0] ^ bit_diff);
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state clears immediately on reset, which abandons any operation
    // in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            br_q       <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            br_q       <= br_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor with WIDTH = 8.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             overflow;
   logic             busy;
   logic             done;

   int nChecks = 0;
   int nFails  = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .diff     (diff),
      .borrow   (borrow),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so that a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Launches one operation and counts the cycles from acceptance until
   // done is seen. Inputs are driven and outputs sampled on falling edges.
   task automatic runOp(input logic [7:0] va, input logic [7:0] vb,
                        input logic vbin, output int lat);
      @(negedge clk);
      a = va; b = vb; bin = vbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #1;
      nChecks++;
      if (diff !== 8'h00 || borrow !== 1'b0 || overflow !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL reset_outputs: got diff=%h borrow=%b ovf=%b busy=%b done=%b, expected all zero",
                  diff, borrow, overflow, busy, done);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] tvA[3]    = '{8'h05, 8'h03, 8'h00};
      logic [7:0] tvB[3]    = '{8'h03, 8'h05, 8'h00};
      logic       tvBin[3]  = '{1'b0, 1'b0, 1'b1};
      logic [7:0] expDiff[3] = '{8'h02, 8'hFE, 8'hFF};
      logic       expBor[3]  = '{1'b0, 1'b1, 1'b1};
      logic       expOvf[3]  = '{1'b0, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         runOp(tvA[i], tvB[i], tvBin[i], lat);
         nChecks++;
         if (lat !== 8) begin
            nFails++;
            $display("[TB] FAIL basic_latency[%0d]: got %0d cycles, expected 8", i, lat);
         end
         nChecks++;
         if (diff !== expDiff[i] || borrow !== expBor[i] || overflow !== expOvf[i]) begin
            nFails++;
            $display("[TB] FAIL basic_result[%0d]: got diff=%h borrow=%b ovf=%b, expected diff=%h borrow=%b ovf=%b",
                     i, diff, borrow, overflow, expDiff[i], expBor[i], expOvf[i]);
         end
         @(negedge clk);
         nChecks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL basic_done_pulse[%0d]: got done=%b busy=%b, expected 0 0", i, done, busy);
         end
         repeat (3) @(negedge clk);
         nChecks++;
         if (diff !== expDiff[i] || borrow !== expBor[i] || overflow !== expOvf[i]) begin
            nFails++;
            $display("[TB] FAIL basic_hold[%0d]: got diff=%h borrow=%b ovf=%b, expected diff=%h borrow=%b ovf=%b",
                     i, diff, borrow, overflow, expDiff[i], expBor[i], expOvf[i]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clk);
      a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      @(negedge clk); lat++;
      @(negedge clk); lat++;
      // Pulse start with different operands while the operation is busy.
      a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
      @(negedge clk); lat++;
      start = 1'b0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      nChecks++;
      if (lat !== 8) begin
         nFails++;
         $display("[TB] FAIL ignore_latency: got %0d cycles, expected 8", lat);
      end
      nChecks++;
      if (diff !== 8'h7F || borrow !== 1'b0 || overflow !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL ignore_result: got diff=%h borrow=%b ovf=%b, expected diff=7f borrow=0 ovf=1",
                  diff, borrow, overflow);
      end
      repeat (2) @(negedge clk);
      nChecks++;
      if (busy !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL ignore_no_restart: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic sawDone;
      @(negedge clk);
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      nChecks++;
      if (diff !== 8'h00 || borrow !== 1'b0 || overflow !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL midreset_outputs: got diff=%h borrow=%b ovf=%b busy=%b done=%b, expected all zero",
                  diff, borrow, overflow, busy, done);
      end
      sawDone = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) sawDone = 1'b1;
         if (i == 2) rst = 1'b0;
      end
      nChecks++;
      if (sawDone !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL midreset_no_done: got done pulse=%b, expected 0", sawDone);
      end
      // Start asserted together with reset release: the very next rising
      // edge must accept it.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nChecks++;
      if (busy !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL midreset_first_accept: got busy=%b, expected 1", busy);
      end
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      nChecks++;
      if (lat !== 8 || diff !== 8'h0F || borrow !== 1'b0 || overflow !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL midreset_result: got lat=%0d diff=%h borrow=%b ovf=%b, expected lat=8 diff=0f borrow=0 ovf=0",
                  lat, diff, borrow, overflow);
      end
      @(negedge clk);
   endtask

   // Start is held high the whole time. Each operation takes 8 BUSY
   // cycles, one DONE cycle and one IDLE cycle to accept the next start,
   // so done pulses arrive every 10 cycles.
   task automatic test_back_to_back();
      logic [7:0] va;
      logic [7:0] vb;
      logic       vbin;
      logic [8:0] wide;
      int         sref;
      logic       expOvf;
      for (int v = 0; v < 1000; v++) begin
         va   = 8'($urandom_range(0, 255));
         vb   = 8'($urandom_range(0, 255));
         vbin = 1'($urandom_range(0, 1));
         wide = {1'b0, va} - {1'b0, vb} - {8'b0, vbin};
         sref = int'($signed(va)) - int'($signed(vb)) - int'(vbin);
         expOvf = (sref < -128) || (sref > 127);
         a = va; b = vb; bin = vbin; start = 1'b1;
         for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i < 9) begin
               nChecks++;
               if (done !== 1'b0 || busy !== 1'b1) begin
                  nFails++;
                  $display("[TB] FAIL b2b_busy[%0d] cycle %0d: got done=%b busy=%b, expected 0 1",
                           v, i, done, busy);
               end
            end else begin
               nChecks++;
               if (done !== 1'b1 || diff !== wide[7:0] || borrow !== wide[8] || overflow !== expOvf) begin
                  nFails++;
                  $display("[TB] FAIL b2b_result[%0d] a=%h b=%h bin=%b: got done=%b diff=%h borrow=%b ovf=%b, expected done=1 diff=%h borrow=%b ovf=%b",
                           v, va, vb, vbin, done, diff, borrow, overflow, wide[7:0], wide[8], expOvf);
               end
            end
         end
         @(negedge clk);
         nChecks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_idle[%0d]: got done=%b busy=%b, expected 0 0", v, done, busy);
         end
      end
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
